// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Instruction fetch front end. Holds a PC/nPC pair that gives one
//   architectural delay slot after a redirect. Issues one instruction-memory
//   read at a time and buffers returned words in a small FIFO toward decode.
//
// Parameters
//   RESET_PC   PC value loaded at reset (nPC gets RESET_PC+4)
//   QDEPTH     instruction queue entries, 2..4
//
// Ports
//   Clk         in   clock, rising edge
//   Reset       in   asynchronous reset, active low
//   imem_req    out  instruction memory read request
//   imem_addr   out  read address (current PC)
//   imem_ready  in   memory response, imem_rdata valid in same cycle
//   imem_rdata  in   returned instruction word
//   br_valid    in   one-cycle redirect pulse from decode
//   br_target   in   redirect target (low two bits ignored)
//   stall       in   blocks issue of new requests
//   inst_valid  out  queue head valid
//   inst        out  queue head instruction word
//   inst_pc     out  fetch address of queue head
//   inst_ready  in   decode accept (pop on inst_valid & inst_ready)
//   pc, npc     out  architectural PC and nPC
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] pc,
    output logic [31:0] npc
);

    localparam int             PW        = (QDEPTH > 2) ? 2 : 1;
    localparam int             CW        = 3;
    localparam logic [CW-1:0]  DEPTH_C   = CW'(QDEPTH);
    localparam logic [PW-1:0]  LAST_C    = PW'(QDEPTH - 1);
    localparam logic [31:0]    RESET_NPC = RESET_PC + 32'd4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    // Cleared by reset, set on the first clock edge afterwards; keeps the
    // request low between reset release and the first rising edge.
    logic          r_run;

    logic [31:0]   r_pc;
    logic [31:0]   r_npc;
    logic          r_redir_pend;
    logic [31:0]   r_redir_tgt;

    logic [31:0]   r_q_inst [QDEPTH];
    logic [31:0]   r_q_pc   [QDEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_fetch_done;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_br_tgt_aligned;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    assign w_br_tgt_aligned = br_target & 32'hFFFF_FFFC;
    assign w_fetch_done     = (r_state == WAIT) && imem_ready;
    assign w_push           = w_fetch_done;
    assign w_pop            = inst_valid && inst_ready;

    // ---------------- handshake FSM ----------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        case (r_state)
            IDLE: begin
                // Only issue when a queue slot is guaranteed for the response.
                if (r_run && !stall && (r_count < DEPTH_C)) begin
                    imem_req    = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- PC / nPC and redirect ----------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc         <= RESET_PC;
            r_npc        <= RESET_NPC;
            r_redir_pend <= 1'b0;
            r_redir_tgt  <= 32'h0;
        end else if (w_fetch_done) begin
            r_pc <= r_npc;
            // A redirect arriving in the completion cycle wins over an older
            // pending one and is consumed immediately.
            if (br_valid) begin
                r_npc <= w_br_tgt_aligned;
            end else if (r_redir_pend) begin
                r_npc <= r_redir_tgt;
            end else begin
                r_npc <= r_npc + 32'd4;
            end
            r_redir_pend <= 1'b0;
        end else if (br_valid) begin
            r_redir_pend <= 1'b1;
            r_redir_tgt  <= w_br_tgt_aligned;
        end
    end

    // ---------------- instruction queue control ----------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- instruction queue storage ----------------
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_q_inst[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]   <= r_pc;
        end
    end

    assign imem_addr  = r_pc;
    assign inst_valid = (r_count != '0);
    assign inst       = r_q_inst[r_rd_ptr];
    assign inst_pc    = r_q_pc[r_rd_ptr];
    assign pc         = r_pc;
    assign npc        = r_npc;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        br_valid;
    logic [31:0] br_target;
    logic        stall;
    logic        inst_ready;

    logic        imem_req,   hi_imem_req;
    logic [31:0] imem_addr,  hi_imem_addr;
    logic        inst_valid, hi_inst_valid;
    logic [31:0] inst,       hi_inst;
    logic [31:0] inst_pc,    hi_inst_pc;
    logic [31:0] pc,         hi_pc;
    logic [31:0] npc,        hi_npc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    // Memory model: word at address A is A + 0x1000_0000.
    assign imem_rdata = imem_addr + 32'h1000_0000;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .br_valid(br_valid), .br_target(br_target), .stall(stall),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .pc(pc), .npc(npc)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) u_dut_hi (
        .Clk(Clk), .Reset(Reset),
        .imem_req(hi_imem_req), .imem_addr(hi_imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .br_valid(br_valid), .br_target(br_target), .stall(stall),
        .inst_valid(hi_inst_valid), .inst(hi_inst), .inst_pc(hi_inst_pc),
        .inst_ready(inst_ready), .pc(hi_pc), .npc(hi_npc)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Leaves the bench just after the first edge following reset release.
    task automatic reset_seq();
        Reset      = 1'b0;
        imem_ready = 1'b1;
        br_valid   = 1'b0;
        br_target  = 32'h0;
        stall      = 1'b0;
        inst_ready = 1'b1;
        #1;
        check_val("rst_req",        {31'h0, imem_req},   32'h0);
        check_val("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        check_val("rst_pc",         pc,                  32'h0000_0000);
        check_val("rst_npc",        npc,                 32'h0000_0004);
        check_val("rst_hi_pc",      hi_pc,               32'hFFFF_FFF8);
        check_val("rst_hi_npc",     hi_npc,              32'hFFFF_FFFC);
        step();
        step();
        Reset = 1'b1;
        #1;
        check_val("req_before_edge", {31'h0, imem_req}, 32'h0);
        step();
    endtask

    // Called in the IDLE cycle of a fetch; returns just after its completion edge.
    task automatic fetch_one(input string tag, input logic [31:0] exp_addr,
                             input bit do_br, input logic [31:0] tgt, input bit chk_head);
        check_val({tag, "_req"},  {31'h0, imem_req}, 32'h1);
        check_val({tag, "_addr"}, imem_addr,         exp_addr);
        step();
        check_val({tag, "_wait_req"},  {31'h0, imem_req}, 32'h1);
        check_val({tag, "_wait_addr"}, imem_addr,         exp_addr);
        if (do_br) begin
            br_valid  = 1'b1;
            br_target = tgt;
        end
        step();
        br_valid = 1'b0;
        if (chk_head) begin
            check_val({tag, "_valid"},   {31'h0, inst_valid}, 32'h1);
            check_val({tag, "_inst_pc"}, inst_pc,             exp_addr);
            check_val({tag, "_inst"},    inst,                exp_addr + 32'h1000_0000);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] seq_lo [4];
        logic [31:0] seq_hi [4];
        seq_lo = '{32'h0, 32'h4, 32'h8, 32'hC};
        seq_hi = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

        Reset      = 1'b1;
        imem_ready = 1'b0;
        br_valid   = 1'b0;
        br_target  = 32'h0;
        stall      = 1'b0;
        inst_ready = 1'b1;
        #2;

        // ---- sequential fetch, memory always ready, wraparound on hi instance
        reset_seq();
        for (int i = 0; i < 4; i++) begin
            check_val("seq_hi_addr", hi_imem_addr, seq_hi[i]);
            fetch_one("seq", seq_lo[i], 1'b0, 32'h0, 1'b1);
        end
        check_val("seq_pc",     pc,     32'h0000_0010);
        check_val("seq_npc",    npc,    32'h0000_0014);
        check_val("seq_hi_pc",  hi_pc,  32'h0000_0008);
        check_val("seq_hi_npc", hi_npc, 32'h0000_000C);

        // ---- redirect coinciding with completion of fetch 0x8
        reset_seq();
        fetch_one("br0", 32'h0, 1'b0, 32'h0, 1'b1);
        fetch_one("br4", 32'h4, 1'b0, 32'h0, 1'b1);
        fetch_one("br8", 32'h8, 1'b1, 32'h100, 1'b1);
        check_val("br_pc_slot",  pc,  32'h0000_000C);
        check_val("br_npc_tgt",  npc, 32'h0000_0100);
        fetch_one("brC", 32'hC, 1'b0, 32'h0, 1'b1);
        check_val("br_pc_tgt",   pc,  32'h0000_0100);
        check_val("br_npc_next", npc, 32'h0000_0104);
        fetch_one("br100", 32'h100, 1'b0, 32'h0, 1'b1);
        fetch_one("br104", 32'h104, 1'b0, 32'h0, 1'b1);

        // ---- pending redirect overwritten, low bits masked
        stall = 1'b1;
        #1;
        check_val("pend_stall_req", {31'h0, imem_req}, 32'h0);
        br_valid  = 1'b1;
        br_target = 32'h0000_0203;
        step();
        br_target = 32'h0000_0307;
        step();
        br_valid = 1'b0;
        check_val("pend_pc_hold",  pc,  32'h0000_0108);
        check_val("pend_npc_hold", npc, 32'h0000_010C);
        stall = 1'b0;
        #1;
        fetch_one("pend108", 32'h108, 1'b0, 32'h0, 1'b1);
        check_val("pend_npc_tgt", npc, 32'h0000_0304);
        fetch_one("pend10C", 32'h10C, 1'b0, 32'h0, 1'b1);
        check_val("pend_pc_tgt",  pc,  32'h0000_0304);
        check_val("pend_npc_inc", npc, 32'h0000_0308);
        fetch_one("pend304", 32'h304, 1'b0, 32'h0, 1'b1);

        // ---- backpressure: queue fills at two entries
        reset_seq();
        inst_ready = 1'b0;
        fetch_one("bp0", 32'h0, 1'b0, 32'h0, 1'b1);
        fetch_one("bp4", 32'h4, 1'b0, 32'h0, 1'b0);
        check_val("bp_full_req",   {31'h0, imem_req},   32'h0);
        check_val("bp_full_valid", {31'h0, inst_valid}, 32'h1);
        check_val("bp_head0_pc",   inst_pc,             32'h0);
        step();
        check_val("bp_full_req2",  {31'h0, imem_req},   32'h0);
        check_val("bp_head0_pc2",  inst_pc,             32'h0);
        inst_ready = 1'b1;
        #1;
        check_val("bp_head0_inst", inst, 32'h1000_0000);
        step();
        check_val("bp_head1_pc",   inst_pc,           32'h0000_0004);
        check_val("bp_head1_inst", inst,              32'h1000_0004);
        check_val("bp_resume_req", {31'h0, imem_req}, 32'h1);
        check_val("bp_resume_adr", imem_addr,         32'h0000_0008);
        fetch_one("bp8", 32'h8, 1'b0, 32'h0, 1'b1);

        // ---- stall raised while waiting on memory
        check_val("st_idle_req",  {31'h0, imem_req}, 32'h1);
        check_val("st_idle_addr", imem_addr,         32'hC);
        step();
        stall      = 1'b1;
        imem_ready = 1'b0;
        #1;
        check_val("st_wait_req0",  {31'h0, imem_req}, 32'h1);
        check_val("st_wait_addr0", imem_addr,         32'hC);
        step();
        check_val("st_wait_req1",  {31'h0, imem_req}, 32'h1);
        check_val("st_wait_addr1", imem_addr,         32'hC);
        step();
        check_val("st_wait_req2",  {31'h0, imem_req}, 32'h1);
        imem_ready = 1'b1;
        step();
        check_val("st_done_req",   {31'h0, imem_req}, 32'h0);
        check_val("st_done_head",  inst_pc,           32'hC);
        check_val("st_done_pc",    pc,                32'h10);
        inst_ready = 1'b0;
        step();
        check_val("st_hold_req",   {31'h0, imem_req},   32'h0);
        check_val("st_hold_valid", {31'h0, inst_valid}, 32'h1);
        stall = 1'b0;
        #1;
        check_val("st_release_req",  {31'h0, imem_req}, 32'h1);
        check_val("st_release_addr", imem_addr,         32'h10);

        // ---- reset asserted mid-WAIT, then stray imem_ready
        step();
        imem_ready = 1'b0;
        Reset      = 1'b0;
        #1;
        check_val("mr_pc",    pc,                  32'h0);
        check_val("mr_npc",   npc,                 32'h4);
        check_val("mr_req",   {31'h0, imem_req},   32'h0);
        check_val("mr_valid", {31'h0, inst_valid}, 32'h0);
        imem_ready = 1'b1;
        step();
        check_val("mr_ready_valid", {31'h0, inst_valid}, 32'h0);
        check_val("mr_ready_pc",    pc,                  32'h0);
        Reset = 1'b1;
        #1;
        check_val("mr_rel_req", {31'h0, imem_req}, 32'h0);
        step();
        check_val("mr_a_valid", {31'h0, inst_valid}, 32'h0);
        check_val("mr_a_req",   {31'h0, imem_req},   32'h1);
        check_val("mr_a_addr",  imem_addr,           32'h0);
        inst_ready = 1'b1;
        step();
        check_val("mr_b_valid", {31'h0, inst_valid}, 32'h0);
        step();
        check_val("mr_c_valid", {31'h0, inst_valid}, 32'h1);
        check_val("mr_c_head",  inst_pc,             32'h0);
        check_val("mr_c_pc",    pc,                  32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
